ppu_cpu_bus_master: RTL
=======================

Name: ppu_cpu_bus_master

Overview:
- Upstream neighbour of the PPU's CPU-side register port. Turns a simple valid/ready request stream (register writes/reads, e.g. from a test CPU model or a DMA engine) into properly timed PPU bus cycles on RS/RnW/n_DBE/D.
- Buffers requests in a small in-order FIFO and returns read data with a one-cycle valid pulse.
- Synchronises the PPU's n_INT back into the requester's domain.

Parameters:
- DEPTH, 4, request FIFO entries (power of two, >=2).
- SETUP_CYC, 2, CLK cycles with RS/RnW/D valid before n_DBE falls (>=1).
- STROBE_CYC, 4, CLK cycles n_DBE is held low (>=1).
- HOLD_CYC, 1, CLK cycles RS/RnW/D are held after n_DBE rises (>=1).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RES  in  1  reset: synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept (= not full).
- req_we  in  1  1 = write, 0 = read.
- req_rs  in  3  PPU register select (0-7).
- req_wdata  in  8  write data.
- rd_valid  out  1  one-cycle pulse: rd_data is valid.
- rd_data  out  8  data sampled on a read.
- busy  out  1  FIFO non-empty or bus cycle in progress.
- RS  out  3  to PPU RS.
- RnW  out  1  to PPU RnW.
- n_DBE  out  1  to PPU n_DBE.
- D_out  out  8  write data to the D pads.
- D_oe  out  1  1 = drive D_out onto D.
- D_in  in  8  D pad input.
- n_INT  in  1  PPU interrupt, asynchronous, active-low.
- irq  out  1  synchronised, active-high interrupt.

Behaviour:
- Reset values: n_DBE=1, RnW=1, RS=0, D_out=0, D_oe=0, rd_valid=0, rd_data=0, req_ready=1, busy=0, irq=0. Both sync flops reset to 1. FIFO pointers are cleared, and entries queued before reset are discarded.
- Reset asserted mid-cycle: on the next edge n_DBE=1 and D_oe=0. No rd_valid is produced for the aborted read.
- Push: when req_valid && req_ready, {we, rs, wdata} is stored at the write pointer. req_ready depends only on the full flag, so there is no push on full even if a pop occurs in the same cycle.
- Pop and push in the same cycle is allowed when the FIFO is not full. Order is strictly preserved between reads and writes.
- FSM states: IDLE, SETUP, STROBE, HOLD. A down-counter is loaded on each state entry.
- IDLE: n_DBE=1, D_oe=0, RnW=1. If the FIFO is non-empty, pop into cycle registers and go to SETUP. RS, RnW=~we, D_out and D_oe=we update on the same edge.
- SETUP: hold SETUP_CYC cycles, then go to STROBE with n_DBE=0.
- STROBE: hold STROBE_CYC cycles. For a read, D_in is captured into rd_data on the edge leaving STROBE, and rd_valid=1 for exactly the following cycle. n_DBE returns to 1 on that same edge and the FSM goes to HOLD.
- HOLD: RS, RnW, D_out and D_oe unchanged for HOLD_CYC cycles, then go to IDLE. D_oe falls on the IDLE entry.
- Minimum period per access is 1+SETUP_CYC+STROBE_CYC+HOLD_CYC CLK cycles (8 at defaults). Back-to-back accesses always pass through one IDLE cycle.
- RS and D_out retain their last values in IDLE (no glitching); only the D_oe and RnW defaults apply there.
- busy = (state!=IDLE) || !empty.
- Interrupt path: two-flop synchroniser on n_INT, irq = ~sync2. Latency is 2 edges; the path is independent of the FSM.
- Pointers are log2(DEPTH) bits plus one wrap bit. full = (MSBs differ && rest equal). Wrap-around is natural modulo 2*DEPTH.

Decomposition:
- Shared package: typedef for the request entry {we, rs[2:0], wdata[7:0]}, the FSM state enum, and constants for register indices (PPUCTRL=0 ... PPUDATA=7).
- One natural sub-module, ppu_req_fifo: a parameterised synchronous FIFO with push, pop, full and empty. The FSM, counter and irq synchroniser stay in the top.

Test Plan:
- Write RS=0 data 0x80 at defaults: n_DBE is low for exactly 4 cycles, starting 3 edges after the accepting edge. D_oe=1 and D_out=0x80 from SETUP through HOLD; RnW=0 throughout.
- Read RS=2 with D_in=0xA0 during STROBE: rd_valid pulses once, rd_data=0xA0. RnW=1 and D_oe=0 for the whole cycle; busy falls after the IDLE return.
- Hold req_valid with 5 writes (RS=6: 0x21, 0x08, then RS=7: 0x11, 0x22, 0x33) while the bus is busy: req_ready deasserts when the FIFO is full. The 5th request is accepted only after the first pop. The bus shows RS/D in exact order, each access 8 cycles apart.
- Interleave write RS=3 0x00, read RS=4, write RS=4 0x55: ordering is preserved, and exactly one rd_valid occurs, between the two write strobes.
- Assert RES for 1 cycle mid-STROBE with 2 entries queued: next edge n_DBE=1, D_oe=0, busy=0, no rd_valid. The queued entries never appear on the bus.
- Drive n_INT 1->0: irq rises on the 2nd edge after the change. n_INT 0->1: irq falls 2 edges later, unaffected by ongoing bus traffic.

Source files
------------

// File: rtl/ppu_cpu_bus_master_pkg.sv
// Purpose: shared types and constants for the PPU CPU-side bus master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppu_cpu_bus_master_pkg;

    // One queued register access; packed so it can travel through a generic FIFO.
    typedef struct packed {
        logic       we;
        logic [2:0] rs;
        logic [7:0] wdata;
    } req_t;

    // Bus-cycle FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_STROBE = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

    // PPU register indices as seen on RS.
    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUMASK   = 3'd1;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] OAMADDR   = 3'd3;
    localparam logic [2:0] OAMDATA   = 3'd4;
    localparam logic [2:0] PPUSCROLL = 3'd5;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ppu_req_fifo.sv
// Purpose: small synchronous in-order FIFO with wrap-bit pointers.
// Latency: push visible at the head one cycle after the accepting edge; head read is combinational.
// Backpressure: push ignored while full, pop ignored while empty.
module ppu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push_vld && !full;
    assign do_pop  = pop && !empty;

    // Same index with opposite wrap bits means every slot is occupied.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign pop_dat = mem[rptr[AW-1:0]];

    // Pointer update; reset discards anything still queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ppu_cpu_bus_master.sv
// Purpose: turns a valid/ready register-access stream into timed PPU RS/RnW/n_DBE/D cycles; syncs n_INT to irq.
// Latency: n_DBE falls SETUP_CYC+1 edges after acceptance; read data returns STROBE_CYC edges later; irq 2 edges.
// Backpressure: req_ready = FIFO not full; accesses drain one at a time with an IDLE cycle between them.
module ppu_cpu_bus_master
    import ppu_cpu_bus_master_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [2:0] req_rs,
    input  logic [7:0] req_wdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [2:0] RS,
    output logic       RnW,
    output logic       n_DBE,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in,
    input  logic       n_INT,
    output logic       irq
);

    localparam int CMAX = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cur_we;
    req_t          req_in;
    req_t          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          sync1;
    logic          sync2;

    assign req_in    = '{we: req_we, rs: req_rs, wdata: req_wdata};
    assign req_ready = ~fifo_full;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign irq       = ~sync2;

    ppu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clk      (CLK),
        .rst      (RES),
        .push_vld (req_valid),
        .push_dat (req_in),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Bus-cycle sequencer: phase counter is reloaded with (length-1) on every phase entry.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur_we   <= 1'b0;
            RS       <= '0;
            RnW      <= 1'b1;
            n_DBE    <= 1'b1;
            D_out    <= '0;
            D_oe     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    n_DBE <= 1'b1;
                    if (pop) begin
                        state  <= ST_SETUP;
                        cnt    <= CW'(SETUP_CYC - 1);
                        cur_we <= head.we;
                        RS     <= head.rs;
                        RnW    <= ~head.we;
                        D_out  <= head.wdata;
                        D_oe   <= head.we;
                    end else begin
                        // RS and D_out keep their last values to avoid pad toggling.
                        RnW  <= 1'b1;
                        D_oe <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state <= ST_STROBE;
                        cnt   <= CW'(STROBE_CYC - 1);
                        n_DBE <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        state <= ST_HOLD;
                        cnt   <= CW'(HOLD_CYC - 1);
                        n_DBE <= 1'b1;
                        if (!cur_we) begin
                            rd_data  <= D_in;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        RnW   <= 1'b1;
                        D_oe  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous active-low interrupt; idles deasserted.
    always_ff @(posedge CLK) begin
        if (RES) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= n_INT;
            sync2 <= sync1;
        end
    end

endmodule
